// File: rtl/spi_slave_duplex.sv
// SPI slave: N-bit MSB-first words, all four CPOL/CPHA modes, fully clk-synchronous.
// Defining SPI_SLAVE_DUPLEX_TX_EN adds the TX holding/shift path that drives miso.
module spi_slave_duplex #(
    parameter int unsigned N           = 8,
    parameter int unsigned CPOL        = 0,
    parameter int unsigned CPHA        = 0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sck,
    input  logic         cs_n,
    input  logic         mosi,
    output logic         miso,
    input  logic [N-1:0] tx_data,
    input  logic         tx_valid,
    output logic         tx_ready,
    output logic [N-1:0] rx_data,
    output logic         rx_valid,
    input  logic         rx_ready,
    output logic         overrun,
    output logic         busy
);
    localparam int unsigned CW       = $clog2(N);
    localparam logic        SCK_IDLE = 1'(CPOL);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sck_prev_q, sck_prev_d;
    logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [N-1:0]           rx_sh_q, rx_sh_d;
    logic [N-1:0]           rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   overrun_q, overrun_d;

    logic sck_s, cs_s, mosi_s;
    logic rise_c, fall_c, lead_c, trail_c, sample_c;
    logic load_c, word_done_c, active_c;

    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // Edge detection on the synchronised sck; leading edge leaves the idle level.
    assign rise_c   = sck_s & ~sck_prev_q;
    assign fall_c   = ~sck_s & sck_prev_q;
    assign lead_c   = (CPOL != 0) ? fall_c : rise_c;
    assign trail_c  = (CPOL != 0) ? rise_c : fall_c;
    assign sample_c = (CPHA != 0) ? trail_c : lead_c;
    assign active_c = (state_q == ACTIVE) && !cs_s;

    always_comb begin
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sck};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        sck_prev_d  = sck_s;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_sh_d     = rx_sh_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        overrun_d   = overrun_q;
        load_c      = 1'b0;
        word_done_c = 1'b0;

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (!cs_s) begin
                    state_d   = ACTIVE;
                    bit_cnt_d = '0;
                    overrun_d = 1'b0;
                    load_c    = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_s) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                end else if (sample_c) begin
                    rx_sh_d = {rx_sh_q[N-2:0], mosi_s};
                    if (bit_cnt_q == CW'(N - 1)) begin
                        bit_cnt_d   = '0;
                        word_done_c = 1'b1;
                        load_c      = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A completed word is dropped only if the previous one is still unclaimed.
        if (word_done_c) begin
            if (rx_valid_q && !rx_ready) begin
                overrun_d = 1'b1;
            end else begin
                rx_data_d  = rx_sh_d;
                rx_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            sck_sync_q  <= {SYNC_STAGES{SCK_IDLE}};
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sck_prev_q  <= SCK_IDLE;
            bit_cnt_q   <= '0;
            rx_sh_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sck_sync_q  <= sck_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sck_prev_q  <= sck_prev_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_sh_q     <= rx_sh_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign overrun  = overrun_q;
    assign busy     = (state_q == ACTIVE);

`ifdef SPI_SLAVE_DUPLEX_TX_EN
    logic [N-1:0] hold_q, hold_d;
    logic [N-1:0] tx_sh_q, tx_sh_d;
    logic         tx_ready_q, tx_ready_d;
    logic         first_q, first_d;
    logic         miso_q, miso_d;
    logic         shift_c;

    assign shift_c = (CPHA != 0) ? lead_c : trail_c;

    // tx_ready_q doubles as the holding-register-empty flag.
    always_comb begin
        hold_d     = hold_q;
        tx_sh_d    = tx_sh_q;
        tx_ready_d = tx_ready_q;
        first_d    = first_q;

        if (load_c) begin
            tx_sh_d = tx_ready_q ? '0 : hold_q;
            first_d = 1'b1;
            if (!tx_ready_q) begin
                tx_ready_d = 1'b1;
            end
        end else if (active_c) begin
            if (sample_c) begin
                first_d = 1'b0;
            end
            // The shift edge ahead of a word's first sample edge must keep the MSB.
            if (shift_c && !first_q) begin
                tx_sh_d = {tx_sh_q[N-2:0], 1'b0};
            end
        end

        if (tx_valid && tx_ready_q) begin
            hold_d     = tx_data;
            tx_ready_d = 1'b0;
        end

        miso_d = (state_d == ACTIVE) ? tx_sh_d[N-1] : 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q     <= '0;
            tx_sh_q    <= '0;
            tx_ready_q <= 1'b1;
            first_q    <= 1'b0;
            miso_q     <= 1'b0;
        end else begin
            hold_q     <= hold_d;
            tx_sh_q    <= tx_sh_d;
            tx_ready_q <= tx_ready_d;
            first_q    <= first_d;
            miso_q     <= miso_d;
        end
    end

    assign miso     = miso_q;
    assign tx_ready = tx_ready_q;
`else
    logic unused_tx;

    assign unused_tx = ^{tx_data, tx_valid, load_c, active_c};
    assign miso      = 1'b0;
    assign tx_ready  = 1'b0;
`endif

endmodule
